// File: rtl/dff_pkg.sv
// Shared types for the din debounce / dff input stage.
package dff_pkg;
  localparam int DEB_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_t;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [DEB_CNT_W-1:0] sat_inc(input logic [DEB_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/din_debounce_if.sv
// Bundle between the debouncer (master, drives din) and the dff stage (slave).
interface din_debounce_if;
  import dff_pkg::*;

  logic                 en;
  logic                 raw_in;
  logic                 din_clean;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [DEB_CNT_W-1:0] change_count;

  modport master (input en, raw_in,
                  output din_clean, rise_pulse, fall_pulse, change_count);
  modport slave  (output en, raw_in,
                  input din_clean, rise_pulse, fall_pulse, change_count);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/din_debounce.sv
// Debounces a noisy async level into a clean din, with edge pulses and a
// saturating count of accepted transitions.
module din_debounce
  import dff_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  din_debounce_if.master bus
);
  localparam logic [DEB_CNT_W-1:0] LAST = DEB_CNT_W'(STABLE_CYCLES - 1);

  logic                 s;
  deb_state_t           state;
  logic [DEB_CNT_W-1:0] stable_cnt;
  logic                 din_clean_q, rise_q, fall_q;
  logic [DEB_CNT_W-1:0] change_cnt_q;

  // Synchronizer is free-running; en only gates the decision logic.
  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.raw_in),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE_LOW;
      stable_cnt   <= '0;
      din_clean_q  <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      change_cnt_q <= '0;
    end else if (!bus.en) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        IDLE_LOW: if (s) begin
          state      <= WAIT_HIGH;
          stable_cnt <= DEB_CNT_W'(1);
        end
        WAIT_HIGH: begin
          if (!s) begin
            state      <= IDLE_LOW;
            stable_cnt <= '0;
          end else if (stable_cnt == LAST) begin
            state        <= IDLE_HIGH;
            stable_cnt   <= '0;
            din_clean_q  <= 1'b1;
            rise_q       <= 1'b1;
            change_cnt_q <= sat_inc(change_cnt_q);
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        IDLE_HIGH: if (!s) begin
          state      <= WAIT_LOW;
          stable_cnt <= DEB_CNT_W'(1);
        end
        WAIT_LOW: begin
          if (s) begin
            state      <= IDLE_HIGH;
            stable_cnt <= '0;
          end else if (stable_cnt == LAST) begin
            state        <= IDLE_LOW;
            stable_cnt   <= '0;
            din_clean_q  <= 1'b0;
            fall_q       <= 1'b1;
            change_cnt_q <= sat_inc(change_cnt_q);
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE_LOW;
          stable_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.din_clean    = din_clean_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.change_count = change_cnt_q;
endmodule

// File: tb/tb_din_debounce.sv
// Randomized + directed bench for din_debounce against a run-length reference model.
module tb_din_debounce;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  // Reference model: 2-deep sample pipe, accepted level, run length of
  // consecutive enabled samples that differ from the accepted level.
  int sq1, sq2, lvl, run, mcnt, mrise, mfall;
  int nr, nf;

  din_debounce_if bus ();

  din_debounce #(.STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic rst);
    int s;
    bus.raw_in = r;
    bus.en     = e;
    reset      = rst;
    @(posedge clk);
    mrise = 0;
    mfall = 0;
    if (rst) begin
      sq1 = 0; sq2 = 0; lvl = 0; run = 0; mcnt = 0;
    end else begin
      s   = sq2;
      sq2 = sq1;
      sq1 = int'(r);
      if (e) begin
        run = (s != lvl) ? run + 1 : 0;
        if (run == STABLE) begin
          lvl  = s;
          run  = 0;
          if (s == 1) mrise = 1; else mfall = 1;
          if (mcnt < 255) mcnt++;
        end
      end
    end
    #1;
    chk("din_clean", int'(bus.din_clean), lvl);
    chk("rise_pulse", int'(bus.rise_pulse), mrise);
    chk("fall_pulse", int'(bus.fall_pulse), mfall);
    chk("change_count", int'(bus.change_count), mcnt);
    chk("both_pulses", int'(bus.rise_pulse & bus.fall_pulse), 0);
    nr += int'(bus.rise_pulse);
    nf += int'(bus.fall_pulse);
    @(negedge clk);
  endtask

  initial begin
    int hold;
    logic r;
    bus.raw_in = 1'b1;
    bus.en     = 1'b1;

    // Reset with raw high and en high
    step(1, 1, 1);
    step(1, 1, 1);
    chk("rst_din", int'(bus.din_clean), 0);
    chk("rst_cnt", int'(bus.change_count), 0);
    chk("rst_rise", int'(bus.rise_pulse), 0);

    // Clean 0->1 with latency check
    repeat (4) step(0, 1, 0);
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0);
      if (i == 4) chk("lat_pre", int'(bus.din_clean), 0);
      if (i == 5) chk("lat_edge", int'(bus.din_clean), 1);
    end
    chk("rise_once", nr, 1);
    chk("cnt_after_rise", int'(bus.change_count), 1);

    // Back low, then a 3-sample glitch high
    repeat (8) step(0, 1, 0);
    chk("fall_cnt", int'(bus.change_count), 2);
    nr = 0; nf = 0;
    repeat (3) step(1, 1, 0);
    repeat (8) step(0, 1, 0);
    chk("glitch_din", int'(bus.din_clean), 0);
    chk("glitch_cnt", int'(bus.change_count), 2);
    chk("glitch_pulses", nr + nf, 0);

    // en freeze after two stable samples
    repeat (4) step(1, 1, 0);
    nr = 0;
    repeat (5) step(1, 0, 0);
    chk("en_hold_din", int'(bus.din_clean), 0);
    chk("en_hold_pulse", nr, 0);
    step(1, 1, 0);
    chk("en_resume1", int'(bus.din_clean), 0);
    step(1, 1, 0);
    chk("en_resume2", int'(bus.din_clean), 1);
    chk("en_resume_rise", int'(bus.rise_pulse), 1);

    // 300 accepted toggles -> saturation
    step(0, 1, 1);
    nr = 0; nf = 0;
    for (int k = 0; k < 300; k++)
      repeat (7) step(logic'(k % 2 == 0), 1, 0);
    chk("sat_cnt", int'(bus.change_count), 255);
    chk("sat_rises", nr, 150);
    chk("sat_falls", nf, 150);

    // Reset (with en low) while in WAIT_LOW
    repeat (7) step(1, 1, 0);
    chk("pre_rst_din", int'(bus.din_clean), 1);
    repeat (4) step(0, 1, 0);
    step(0, 0, 1);
    chk("wl_rst_din", int'(bus.din_clean), 0);
    chk("wl_rst_fall", int'(bus.fall_pulse), 0);
    chk("wl_rst_cnt", int'(bus.change_count), 0);
    step(0, 1, 0);
    chk("wl_post_fall", int'(bus.fall_pulse), 0);

    // Randomized bursts of varying length, random en, rare reset
    r = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r    = ~r;
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++)
        step(r, logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
